// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift-left / shift-right / load) with a saturating shift counter and done pulse.
// Optional rotate input, enabled by defining SHIFT_REG_UNIV_ROTATE_EN.
module shift_reg_univ #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             feed_lsb, feed_msb;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  // Rotation recirculates the bit falling off the opposite end.
  assign feed_lsb = rotate ? q_q[WIDTH-1] : sin_lsb;
  assign feed_msb = rotate ? q_q[0]       : sin_msb;
`else
  assign feed_lsb = sin_lsb;
  assign feed_msb = sin_msb;
`endif

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    case (mode_e'(mode))
      MODE_HOLD: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
      MODE_LEFT: begin
        q_d = {q_q[WIDTH-2:0], feed_lsb};
        if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_q == CNT_MAX - 1'b1);
        end
      end
      MODE_RIGHT: begin
        q_d = {feed_msb, q_q[WIDTH-1:1]};
        if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_q == CNT_MAX - 1'b1);
        end
      end
      MODE_LOAD: begin
        q_d   = d;
        cnt_d = '0;
      end
      default: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign so_msb    = q_q[WIDTH-1];
  assign so_lsb    = q_q[0];
  assign shift_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8): directed vectors push expectations,
// a monitor on the falling edge pops and compares them.
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_lsb;
  logic             sin_msb;
  logic             rotate;
  logic [WIDTH-1:0] q;
  logic             so_msb;
  logic             so_lsb;
  logic [CNT_W-1:0] shift_cnt;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             so_msb;
    logic             so_lsb;
    string            name;
  } exp_t;

  exp_t exp_queue[$];
  int   tests_run;
  int   tests_failed;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .d         (d),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rotate    (rotate),
`endif
    .q         (q),
    .so_msb    (so_msb),
    .so_lsb    (so_lsb),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [WIDTH-1:0] e_q, input logic [CNT_W-1:0] e_cnt,
                            input logic e_done, input string name);
    exp_t e;
    e.q      = e_q;
    e.cnt    = e_cnt;
    e.done   = e_done;
    e.so_msb = e_q[WIDTH-1];
    e.so_lsb = e_q[0];
    e.name   = name;
    exp_queue.push_back(e);
  endtask

  // Drive one cycle of inputs just after a falling edge, expect the result after the rising edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [WIDTH-1:0] dv,
                               input logic sl, input logic sm, input logic rot,
                               input logic [WIDTH-1:0] e_q, input logic [CNT_W-1:0] e_cnt,
                               input logic e_done, input string name);
    #1;
    mode    = m;
    d       = dv;
    sin_lsb = sl;
    sin_msb = sm;
    rotate  = rot;
    @(posedge clk);
    pushExpect(e_q, e_cnt, e_done, name);
    @(negedge clk);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_queue.size() > 0) begin
        e = exp_queue.pop_front();
        checkOutput(e.name, "q",         q,                    e.q);
        checkOutput(e.name, "shift_cnt", WIDTH'(shift_cnt),    WIDTH'(e.cnt));
        checkOutput(e.name, "done",      WIDTH'(done),         WIDTH'(e.done));
        checkOutput(e.name, "so_msb",    WIDTH'(so_msb),       WIDTH'(e.so_msb));
        checkOutput(e.name, "so_lsb",    WIDTH'(so_lsb),       WIDTH'(e.so_lsb));
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    mode    = 2'b00;
    d       = '0;
    sin_lsb = 1'b0;
    sin_msb = 1'b0;
    rotate  = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 8'h00, 0, 0, 0, 8'h00, 4'd0, 0, "reset");
    #1 rst_n = 1'b1;

    // Asynchronous clear between edges
    applyStimulus(2'b11, 8'h5A, 0, 0, 0, 8'h5A, 4'd0, 0, "load_5a");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hB5, 4'd1, 0, "shift_5a");
    #1 mode = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b0;
    pushExpect(8'h00, 4'd0, 0, "async_clr");
    @(negedge clk);
    applyStimulus(2'b11, 8'hFF, 0, 0, 0, 8'h00, 4'd0, 0, "rst_hold_load");
    applyStimulus(2'b01, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, "rst_hold_shift");
    #1 rst_n = 1'b1;

    // Load and hold
    applyStimulus(2'b11, 8'hA5, 0, 0, 0, 8'hA5, 4'd0, 0, "load_a5");
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b00, 8'h00, 1, 1, 0, 8'hA5, 4'd0, 0, "hold_a5");

    // Left shift to saturation
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h4B, 4'd1, 0, "shl1");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h97, 4'd2, 0, "shl2");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h2F, 4'd3, 0, "shl3");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h5F, 4'd4, 0, "shl4");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hBF, 4'd5, 0, "shl5");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h7F, 4'd6, 0, "shl6");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hFF, 4'd7, 0, "shl7");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hFF, 4'd8, 1, "shl8_done");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hFF, 4'd8, 0, "shl9_sat");
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 8'hFF, 4'd8, 0, "hold_sat");

    // Right shift and serial outputs
    applyStimulus(2'b11, 8'h81, 0, 0, 0, 8'h81, 4'd0, 0, "load_81");
    applyStimulus(2'b10, 8'h00, 0, 0, 0, 8'h40, 4'd1, 0, "shr1");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hA0, 4'd2, 0, "shr2");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hD0, 4'd3, 0, "shr3");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hE8, 4'd4, 0, "shr4");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hF4, 4'd5, 0, "shr5");

    // Load re-arms the counter; mixed directions all count
    applyStimulus(2'b11, 8'h33, 0, 0, 0, 8'h33, 4'd0, 0, "load_33");
    applyStimulus(2'b01, 8'h00, 0, 0, 0, 8'h66, 4'd1, 0, "mix1");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hB3, 4'd2, 0, "mix2");
    applyStimulus(2'b01, 8'h00, 0, 0, 0, 8'h66, 4'd3, 0, "mix3");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hCD, 4'd4, 0, "mix4");
    applyStimulus(2'b10, 8'h00, 0, 0, 0, 8'h66, 4'd5, 0, "mix5");
    applyStimulus(2'b10, 8'h00, 0, 0, 0, 8'h33, 4'd6, 0, "mix6");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'h67, 4'd7, 0, "mix7");
    applyStimulus(2'b01, 8'h00, 0, 0, 0, 8'hCE, 4'd8, 1, "mix8_done");
    applyStimulus(2'b10, 8'h00, 0, 1, 0, 8'hE7, 4'd8, 0, "mix9_sat");
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 8'hE7, 4'd8, 0, "mix_hold");

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotation ignores the serial inputs
    applyStimulus(2'b11, 8'h81, 0, 0, 0, 8'h81, 4'd0, 0, "rot_load1");
    applyStimulus(2'b01, 8'h00, 1'($urandom), 1'($urandom), 1, 8'h03, 4'd1, 0, "rotl1");
    applyStimulus(2'b11, 8'h81, 0, 0, 0, 8'h81, 4'd0, 0, "rot_load2");
    applyStimulus(2'b10, 8'h00, 1'($urandom), 1'($urandom), 1, 8'hC0, 4'd1, 0, "rotr1");
    applyStimulus(2'b10, 8'h00, 1'($urandom), 1'($urandom), 1, 8'h60, 4'd2, 0, "rotr2");
    applyStimulus(2'b10, 8'h00, 1'($urandom), 1'($urandom), 1, 8'h30, 4'd3, 0, "rotr3");
    applyStimulus(2'b01, 8'h00, 1'($urandom), 1'($urandom), 1, 8'h60, 4'd4, 0, "rotl2");
    applyStimulus(2'b01, 8'h00, 1, 0, 0, 8'hC1, 4'd5, 0, "rot_off");
`endif

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_queue.size() > 0; i++)
      @(negedge clk);
    #1;
    if (exp_queue.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, 0 required", exp_queue.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
